// File: rtl/line_buffer_pkg.sv
// rtl/line_buffer_pkg.sv - shared widths, response tag type and depth helper for the line buffer
package line_buffer_pkg;
    localparam int DATA_W      = 32;
    localparam int BE_W        = DATA_W / 8;
    localparam int LINES_CNT_W = 16;

    typedef struct packed {
        logic valid;
        logic eop;
    } rsp_tag_t;

    function automatic int unsigned depth_of(input int unsigned addr_w);
        return 32'd1 << addr_w;
    endfunction
endpackage

// File: rtl/line_buffer_ram.sv
// rtl/line_buffer_ram.sv - single-port line RAM with byte-lane writes and registered read data
module line_buffer_ram
    import line_buffer_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] addr,
    input  logic              we,
    input  logic [BE_W-1:0]   be,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    output logic [DATA_W-1:0] q
);
    localparam int DEPTH = int'(depth_of(ADDR_W));

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < BE_W; b++) begin
                if (be[b]) begin
                    mem[addr][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

    // Only the output register is reset; q holds between reads so readdata holds too.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            q <= '0;
        end else if (re) begin
            q <= mem[addr];
        end
    end
endmodule

// File: rtl/line_buffer_responder.sv
// rtl/line_buffer_responder.sv - pipelined slave plus priority capture port sharing one line buffer
module line_buffer_responder
    import line_buffer_pkg::*;
#(
    parameter int ADDR_W       = 10,
    parameter int READ_LATENCY = 2
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [ADDR_W-1:0]      slave_address,
    input  logic [BE_W-1:0]        slave_byteenable,
    input  logic                   slave_read,
    input  logic                   slave_write,
    input  logic [DATA_W-1:0]      slave_writedata,
    output logic                   slave_waitrequest,
    output logic [DATA_W-1:0]      slave_readdata,
    output logic                   slave_readdatavalid,
    output logic                   slave_endofpacket,
    input  logic                   cap_valid,
    input  logic                   cap_sop,
    input  logic [DATA_W-1:0]      cap_data,
    output logic                   line_done,
    output logic [LINES_CNT_W-1:0] lines_captured
);
    localparam logic [ADDR_W-1:0]      LAST_ADDR = '1;
    localparam logic [LINES_CNT_W-1:0] CNT_MAX   = '1;

    logic [ADDR_W-1:0] cap_ptr;
    logic [ADDR_W-1:0] cap_addr;
    logic              rd_accept;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [BE_W-1:0]   ram_be;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_q;
    rsp_tag_t          tag_pipe [READ_LATENCY];

    // Capture owns the RAM whenever it is present, so the slave simply stalls.
    assign slave_waitrequest = cap_valid;
    assign cap_addr          = cap_sop ? '0 : cap_ptr;
    assign rd_accept         = slave_read & ~slave_write & ~cap_valid;
    assign ram_we            = cap_valid | slave_write;
    assign ram_addr          = cap_valid ? cap_addr : slave_address;
    assign ram_be            = cap_valid ? '1 : slave_byteenable;
    assign ram_wdata         = cap_valid ? cap_data : slave_writedata;

    line_buffer_ram #(.ADDR_W(ADDR_W)) u_ram (
        .clk     (clk),
        .reset_n (reset_n),
        .addr    (ram_addr),
        .we      (ram_we),
        .be      (ram_be),
        .wdata   (ram_wdata),
        .re      (rd_accept),
        .q       (ram_q)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cap_ptr        <= '0;
            line_done      <= 1'b0;
            lines_captured <= '0;
        end else begin
            line_done <= cap_valid && (cap_addr == LAST_ADDR);
            if (cap_valid) begin
                cap_ptr <= cap_addr + 1'b1;
                if ((cap_addr == LAST_ADDR) && (lines_captured != CNT_MAX)) begin
                    lines_captured <= lines_captured + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < READ_LATENCY; i++) begin
                tag_pipe[i] <= '0;
            end
        end else begin
            tag_pipe[0] <= rsp_tag_t'{valid: rd_accept,
                                      eop:   rd_accept && (slave_address == LAST_ADDR)};
            for (int i = 1; i < READ_LATENCY; i++) begin
                tag_pipe[i] <= tag_pipe[i-1];
            end
        end
    end

    assign slave_readdatavalid = tag_pipe[READ_LATENCY-1].valid;
    assign slave_endofpacket   = tag_pipe[READ_LATENCY-1].eop;

    // Data stage i is aligned with tag stage i+1; it only loads when a response passes through.
    generate
        if (READ_LATENCY == 1) begin : g_direct
            assign slave_readdata = ram_q;
        end else begin : g_regs
            logic [DATA_W-1:0] data_pipe [READ_LATENCY-1];

            always_ff @(posedge clk) begin
                if (!reset_n) begin
                    for (int i = 0; i < READ_LATENCY-1; i++) begin
                        data_pipe[i] <= '0;
                    end
                end else begin
                    if (tag_pipe[0].valid) begin
                        data_pipe[0] <= ram_q;
                    end
                    for (int i = 1; i < READ_LATENCY-1; i++) begin
                        if (tag_pipe[i].valid) begin
                            data_pipe[i] <= data_pipe[i-1];
                        end
                    end
                end
            end

            assign slave_readdata = data_pipe[READ_LATENCY-2];
        end
    endgenerate
endmodule
